conv_pingpong_buf: RTL
======================

# conv_pingpong_buf

Parametrised ping-pong buffer between a convolution layer's output stream and the next stage, typically a 2x2 pooling unit. It holds two banks of ROWS x COLS pixels, each pixel carrying CH channels in parallel. The writer fills one bank while the reader drains the other. Address generation, bank arbitration and backpressure are all internal, and the reader can emit raster order or 2x2-window order.

## Interface
- DATA_W, 8: bits per channel sample
- CH, 1: channels per pixel, carried in parallel on one beat
- COLS, 26: pixels per row
- ROWS, 2: rows per bank
- RD_MODE, 0: 0 = raster read order, 1 = 2x2 window order (ROWS and COLS must be even)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous abort; same effect as rst on all control state
- in_valid  in  1  write beat offered
- in_ready  out  1  buffer can accept the beat
- in_data  in  CH*DATA_W  pixel; channel k occupies bits [k*DATA_W +: DATA_W]
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the beat
- out_data  out  CH*DATA_W  pixel read from the buffer
- out_win_last  out  1  last beat of a window (mode 1) or of a row (mode 0)
- out_last  out  1  last beat of a bank
- bank_full  out  2  per-bank full flag, for status and debug

## Operation
- Storage is 2 x ROWS*COLS words of CH*DATA_W bits, inferred as one simple dual-port RAM. Contents are not reset.
- Control state:
  - wr_sel and rd_sel: 1-bit bank pointers.
  - full[1:0]: per-bank full flags.
  - Write counters: wr_row, wr_col.
  - Read counters: rd_row, rd_col in mode 0; row pair rp, column pair cp and 2-bit phase ph in mode 1.
- Write side:
  - in_ready = !full[wr_sel].
  - A beat is accepted when in_valid && in_ready. The pixel is written at wr_row*COLS+wr_col of bank wr_sel, and wr_col advances, wrapping to 0 and incrementing wr_row.
  - On the beat at (ROWS-1, COLS-1), full[wr_sel] is set, wr_sel toggles and the counters return to 0.
- Read side:
  - Read order in mode 0 is linear, 0..ROWS*COLS-1.
  - Read order in mode 1 is row = 2*rp + ph[1], col = 2*cp + ph[0].
    - ph increments 0..3.
    - cp advances when ph wraps.
    - rp advances when cp wraps at COLS/2-1.
  - A read is issued when full[rd_sel] && (!out_valid || out_ready).
- Read-side flags:
  - out_win_last is high on mode-0 col = COLS-1 and on mode-1 ph = 3.
  - out_last is high on the final address of the bank.
  - Both flags are registered alongside out_data.
- On the read of the final address, full[rd_sel] clears and rd_sel toggles.
- Simultaneous set and clear of different banks' flags in one cycle are both applied. The same bank cannot be set and cleared in one cycle.
- rst or clear:
  - wr_sel = rd_sel = 0, full = 00, all counters 0.
  - out_valid = 0, out_data = 0, out_win_last = out_last = 0.
  - in_ready = 1 from the first cycle after reset.
  - A bank partially written or drained at reset is discarded. rst takes priority over clear.

## Timing
- Read latency is 1 cycle. A read issued in cycle t sets out_valid, out_data and flags at the edge ending t.
- out_data is held stable while out_valid && !out_ready.
- No read is issued while the output is stalled.
- Bank hand-off:
  - The final write beat is accepted at edge E, which sets full.
  - The earliest read is issued in the cycle after E, giving the first out_valid at edge E+1.
- A bank freed by its final read at edge F can accept writes from the cycle after F, since in_ready is derived from registered flags.
- Throughput: 1 beat/cycle on each side in steady state. The writer stalls only when both banks are full.

## Test plan
- Raster fill/drain: defaults, RD_MODE=0, out_ready=1, write values 0..51 -> out_data emits 0..51 in order. out_win_last is high at 25 and 51; out_last is high at 51; first out_valid arrives 1 cycle after full is set.
- Window order: COLS=4, ROWS=2, RD_MODE=1, write 0..7 -> output sequence 0,1,4,5,2,3,6,7. out_win_last is high on 5 and 7; out_last is high on 7.
- Backpressure: random out_ready at 50% over 3 banks -> no lost or duplicated beats, and out_data is stable during every stall.
- Ping-pong stall: out_ready=0, write 2 banks -> bank_full=11 and in_ready=0. Raise out_ready -> in_ready returns 1 the cycle after the 52nd read; third-bank data follows in order.
- Reset mid-drain: assert rst during the 10th read beat -> next cycle out_valid=0, bank_full=00, in_ready=1. A fresh bank then reads back correctly from address 0.
- Multichannel: CH=3, in_data = {k+2, k+1, k} per beat -> each channel lane is returned intact in its own DATA_W slice.

Source files
------------

// File: rtl/conv_pingpong_buf_if.sv
// conv_pingpong_buf_if
//   Stream interface of the ping-pong buffer: write-side valid/ready/data from
//   the convolution layer and read-side valid/ready/data plus framing flags
//   towards the next stage.
//   slave  : the buffer itself (accepts in_*, produces out_*)
//   master : the surrounding logic / testbench (produces in_*, accepts out_*)
//   Parameters DATA_W and CH must match the buffer instance.
interface conv_pingpong_buf_if #(
   parameter int DATA_W = 8,
   parameter int CH     = 1
);
   logic                 in_valid;
   logic                 in_ready;
   logic [CH*DATA_W-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [CH*DATA_W-1:0] out_data;
   logic                 out_win_last;
   logic                 out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_win_last, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_win_last, out_last
   );
endinterface

// File: rtl/conv_pingpong_buf.sv
// conv_pingpong_buf
//   Two-bank ping-pong buffer between a convolution output stream and the next
//   stage. The writer fills one ROWS x COLS bank while the reader drains the
//   other, in raster order (RD_MODE=0) or 2x2-window order (RD_MODE=1).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over clear)
//   clear      synchronous abort, same effect as rst on control state
//   bus        conv_pingpong_buf_if.slave: in_valid/in_ready/in_data write
//              stream, out_valid/out_ready/out_data/out_win_last/out_last read
//              stream (1-cycle read latency, output held while stalled)
//   bank_full  per-bank full flags (status/debug)
module conv_pingpong_buf #(
   parameter int DATA_W  = 8,
   parameter int CH      = 1,
   parameter int COLS    = 26,
   parameter int ROWS    = 2,
   parameter int RD_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   conv_pingpong_buf_if.slave        bus,
   output logic [1:0]                bank_full
);
   localparam int W  = CH * DATA_W;
   localparam int N  = ROWS * COLS;
   localparam int AW = $clog2(2 * N);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic          wr_sel, rd_sel;
   logic [1:0]    full, full_nxt;
   logic [RW-1:0] wr_row;
   logic [CW-1:0] wr_col;
   logic          wr_fire, wr_done, rd_fire, rd_done;
   logic [AW-1:0] wr_addr, rd_addr, rd_loc;
   logic          rd_win_last, rd_is_last;
   logic [W-1:0]  mem [2*N];

   // in_ready depends only on registered flags, so a freed bank becomes
   // writable the cycle after its final read.
   assign bus.in_ready = !full[wr_sel];
   assign wr_fire      = bus.in_valid && !full[wr_sel];
   assign wr_done      = wr_fire && (wr_row == RW'(ROWS-1)) && (wr_col == CW'(COLS-1));
   assign wr_addr      = (wr_sel ? AW'(N) : AW'(0)) + AW'(wr_row) * AW'(COLS) + AW'(wr_col);

   // A read is issued whenever the output register is empty or being drained.
   assign rd_fire   = full[rd_sel] && (!bus.out_valid || bus.out_ready);
   assign rd_done   = rd_fire && rd_is_last;
   assign rd_addr   = (rd_sel ? AW'(N) : AW'(0)) + rd_loc;
   assign bank_full = full;

   // Writer and reader never own the same bank, so set and clear below always
   // target different bits.
   always_comb begin
      full_nxt = full;
      if (wr_done) full_nxt[wr_sel] = 1'b1;
      if (rd_done) full_nxt[rd_sel] = 1'b0;
   end

   // Storage: simple dual-port RAM, contents not reset.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_addr] <= bus.in_data;
   end

   // Write-side counters, bank pointers and full flags.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         full   <= 2'b00;
         wr_row <= '0;
         wr_col <= '0;
      end else begin
         if (wr_fire) begin
            if (wr_col == CW'(COLS-1)) begin
               wr_col <= '0;
               wr_row <= (wr_row == RW'(ROWS-1)) ? '0 : wr_row + RW'(1);
            end else begin
               wr_col <= wr_col + CW'(1);
            end
            if (wr_done) wr_sel <= !wr_sel;
         end
         if (rd_done) rd_sel <= !rd_sel;
         full <= full_nxt;
      end
   end

   // Output register: RAM read data and flags land together one cycle after issue.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         bus.out_valid    <= 1'b0;
         bus.out_data     <= '0;
         bus.out_win_last <= 1'b0;
         bus.out_last     <= 1'b0;
      end else if (rd_fire) begin
         bus.out_valid    <= 1'b1;
         bus.out_data     <= mem[rd_addr];
         bus.out_win_last <= rd_win_last;
         bus.out_last     <= rd_is_last;
      end else if (bus.out_ready) begin
         bus.out_valid    <= 1'b0;
      end
   end

   // Read address generation; only the selected order's counters exist.
   if (RD_MODE == 0) begin : g_raster
      logic [RW-1:0] rd_row;
      logic [CW-1:0] rd_col;

      always_ff @(posedge clk) begin
         if (rst || clear) begin
            rd_row <= '0;
            rd_col <= '0;
         end else if (rd_fire) begin
            if (rd_col == CW'(COLS-1)) begin
               rd_col <= '0;
               rd_row <= (rd_row == RW'(ROWS-1)) ? '0 : rd_row + RW'(1);
            end else begin
               rd_col <= rd_col + CW'(1);
            end
         end
      end

      assign rd_loc      = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
      assign rd_win_last = (rd_col == CW'(COLS-1));
      assign rd_is_last  = rd_win_last && (rd_row == RW'(ROWS-1));
   end else begin : g_window
      localparam int PW = (ROWS > 2) ? $clog2(ROWS/2) : 1;
      localparam int QW = (COLS > 2) ? $clog2(COLS/2) : 1;
      logic [PW-1:0] rp;
      logic [QW-1:0] cp;
      logic [1:0]    ph;

      // ph walks the 2x2 window (TL, TR, BL, BR); cp then rp step on wrap.
      always_ff @(posedge clk) begin
         if (rst || clear) begin
            rp <= '0;
            cp <= '0;
            ph <= '0;
         end else if (rd_fire) begin
            ph <= ph + 2'd1;
            if (ph == 2'd3) begin
               if (cp == QW'(COLS/2-1)) begin
                  cp <= '0;
                  rp <= (rp == PW'(ROWS/2-1)) ? '0 : rp + PW'(1);
               end else begin
                  cp <= cp + QW'(1);
               end
            end
         end
      end

      assign rd_loc      = (AW'(rp) * AW'(2) + AW'(ph[1])) * AW'(COLS)
                         + AW'(cp) * AW'(2) + AW'(ph[0]);
      assign rd_win_last = (ph == 2'd3);
      assign rd_is_last  = rd_win_last && (cp == QW'(COLS/2-1)) && (rp == PW'(ROWS/2-1));
   end
endmodule
